// File: rtl/uart_pkg.sv
// Shared definitions for the UART command-frame path: frame constants, state
// encoding and the inter-byte timeout calculation.
package uart_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'h55;
  localparam int         FRAME_LEN      = 6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR_H = 3'd2,
    S_ADDR_L = 3'd3,
    S_DATA   = 3'd4,
    S_CHK    = 3'd5
  } state_t;

  // Character time is 10 bit times (start + 8 data + stop).
  function automatic int to_cycles(input int clk_freq, input int uart_bps,
                                   input int timeout_bytes);
    return timeout_bytes * 10 * (clk_freq / uart_bps);
  endfunction

endpackage

// File: rtl/uart_byte_stb.sv
// Turns the receiver's level-style done flag into a single-cycle byte strobe
// and presents the received byte alongside it.
module uart_byte_stb (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_done,
  input  logic [7:0] uart_data,
  output logic       byte_stb,
  output logic [7:0] byte_data
);

  logic done_d0_q;
  logic done_d0_d;

  assign done_d0_d = uart_done;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      done_d0_q <= 1'b0;
    end else begin
      done_d0_q <= done_d0_d;
    end
  end

  // Combinational strobe so the consumer reacts on the first edge after done rises.
  assign byte_stb  = uart_done & ~done_d0_q;
  assign byte_data = byte_stb ? uart_data : 8'h00;

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles 6-byte command frames (header, cmd, addr_hi, addr_lo, data, checksum)
// from the UART byte stream, with checksum and inter-byte timeout checking.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int         CLK_FREQ      = 50000000,
  parameter int         UART_BPS      = 9600,
  parameter logic [7:0] HEADER        = HEADER_DEFAULT,
  parameter int         TIMEOUT_BYTES = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        uart_done,
  input  logic [7:0]  uart_data,
  output logic        frame_valid,
  output logic [7:0]  frame_cmd,
  output logic [15:0] frame_addr,
  output logic [7:0]  frame_wdata,
  output logic        err_chk,
  output logic        err_timeout,
  output logic        busy
);

  localparam int             TO_CYCLES = to_cycles(CLK_FREQ, UART_BPS, TIMEOUT_BYTES);
  localparam int             CNT_W     = $clog2(TO_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_CYCLES - 1);

  logic       byte_stb;
  logic [7:0] byte_data;

  uart_byte_stb u_byte_stb (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .uart_done (uart_done),
    .uart_data (uart_data),
    .byte_stb  (byte_stb),
    .byte_data (byte_data)
  );

  state_t           state_q, state_d;
  logic [7:0]       sum_q, sum_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       addr_hi_q, addr_hi_d;
  logic [7:0]       addr_lo_q, addr_lo_d;
  logic [7:0]       data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_valid_q, frame_valid_d;
  logic [7:0]       frame_cmd_q, frame_cmd_d;
  logic [15:0]      frame_addr_q, frame_addr_d;
  logic [7:0]       frame_wdata_q, frame_wdata_d;
  logic             err_chk_q, err_chk_d;
  logic             err_timeout_q, err_timeout_d;
  logic             busy_q, busy_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= S_IDLE;
      sum_q         <= 8'h00;
      cmd_q         <= 8'h00;
      addr_hi_q     <= 8'h00;
      addr_lo_q     <= 8'h00;
      data_q        <= 8'h00;
      cnt_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_cmd_q   <= 8'h00;
      frame_addr_q  <= 16'h0000;
      frame_wdata_q <= 8'h00;
      err_chk_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sum_q         <= sum_d;
      cmd_q         <= cmd_d;
      addr_hi_q     <= addr_hi_d;
      addr_lo_q     <= addr_lo_d;
      data_q        <= data_d;
      cnt_q         <= cnt_d;
      frame_valid_q <= frame_valid_d;
      frame_cmd_q   <= frame_cmd_d;
      frame_addr_q  <= frame_addr_d;
      frame_wdata_q <= frame_wdata_d;
      err_chk_q     <= err_chk_d;
      err_timeout_q <= err_timeout_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    sum_d         = sum_q;
    cmd_d         = cmd_q;
    addr_hi_d     = addr_hi_q;
    addr_lo_d     = addr_lo_q;
    data_d        = data_q;
    cnt_d         = (state_q == S_IDLE) ? '0 : cnt_q + CNT_W'(1);
    frame_valid_d = 1'b0;
    frame_cmd_d   = frame_cmd_q;
    frame_addr_d  = frame_addr_q;
    frame_wdata_d = frame_wdata_q;
    err_chk_d     = 1'b0;
    err_timeout_d = 1'b0;

    // A byte arriving on the expiry cycle takes priority over the timeout.
    if (byte_stb) begin
      cnt_d = '0;
      case (state_q)
        S_IDLE: begin
          if (byte_data == HEADER) begin
            state_d = S_CMD;
            sum_d   = 8'h00;
          end
        end
        S_CMD: begin
          cmd_d   = byte_data;
          sum_d   = sum_q + byte_data;
          state_d = S_ADDR_H;
        end
        S_ADDR_H: begin
          addr_hi_d = byte_data;
          sum_d     = sum_q + byte_data;
          state_d   = S_ADDR_L;
        end
        S_ADDR_L: begin
          addr_lo_d = byte_data;
          sum_d     = sum_q + byte_data;
          state_d   = S_DATA;
        end
        S_DATA: begin
          data_d  = byte_data;
          sum_d   = sum_q + byte_data;
          state_d = S_CHK;
        end
        S_CHK: begin
          if (byte_data == sum_q) begin
            frame_valid_d = 1'b1;
            frame_cmd_d   = cmd_q;
            frame_addr_d  = {addr_hi_q, addr_lo_q};
            frame_wdata_d = data_q;
          end else begin
            err_chk_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && cnt_q == TO_LAST) begin
      err_timeout_d = 1'b1;
      state_d       = S_IDLE;
      cnt_d         = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  assign frame_valid = frame_valid_q;
  assign frame_cmd   = frame_cmd_q;
  assign frame_addr  = frame_addr_q;
  assign frame_wdata = frame_wdata_q;
  assign err_chk     = err_chk_q;
  assign err_timeout = err_timeout_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser, scaled to 10 clocks per bit so the
// timeout is 300 cycles.
module tb_uart_frame_parser;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        uart_done;
  logic [7:0]  uart_data;
  logic        frame_valid;
  logic [7:0]  frame_cmd;
  logic [15:0] frame_addr;
  logic [7:0]  frame_wdata;
  logic        err_chk;
  logic        err_timeout;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;
  int fv_cnt     = 0;
  int ec_cnt     = 0;
  int et_cnt     = 0;
  int fv0, ec0, et0;

  uart_frame_parser #(
    .CLK_FREQ      (96000),
    .UART_BPS      (9600),
    .HEADER        (8'h55),
    .TIMEOUT_BYTES (3)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .uart_done   (uart_done),
    .uart_data   (uart_data),
    .frame_valid (frame_valid),
    .frame_cmd   (frame_cmd),
    .frame_addr  (frame_addr),
    .frame_wdata (frame_wdata),
    .err_chk     (err_chk),
    .err_timeout (err_timeout),
    .busy        (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Count high cycles of each strobe, sampled mid-cycle.
  always @(negedge sys_clk) begin
    if (frame_valid) fv_cnt++;
    if (err_chk)     ec_cnt++;
    if (err_timeout) et_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    @(posedge sys_clk); #1;
    uart_done = 1'b1;
    uart_data = b;
    repeat (hold) @(posedge sys_clk);
    #1;
    uart_done = 1'b0;
    uart_data = 8'h00;
    repeat (gap) @(posedge sys_clk);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] ah,
                            input logic [7:0] al, input logic [7:0] d,
                            input logic [7:0] ck);
    send_byte(8'h55, 20, 10);
    send_byte(c, 20, 10);
    send_byte(ah, 20, 10);
    send_byte(al, 20, 10);
    send_byte(d, 20, 10);
    send_byte(ck, 20, 10);
  endtask

  task automatic snap();
    fv0 = fv_cnt;
    ec0 = ec_cnt;
    et0 = et_cnt;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    uart_done = 1'b0;
    uart_data = 8'h00;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    check("rst_frame_cmd",   {24'd0, frame_cmd},   32'd0);
    check("rst_frame_addr",  {16'd0, frame_addr},  32'd0);
    check("rst_frame_wdata", {24'd0, frame_wdata}, 32'd0);
    check("rst_err_chk",     {31'd0, err_chk},     32'd0);
    check("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
    check("rst_busy",        {31'd0, busy},        32'd0);
    sys_rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);

    // Good frame 55 01 12 34 AB F2, checksum byte driven by hand for latency
    snap();
    send_byte(8'h55, 20, 10);
    check("busy_after_hdr", {31'd0, busy}, 32'd1);
    send_byte(8'h01, 20, 10);
    send_byte(8'h12, 20, 10);
    send_byte(8'h34, 20, 10);
    send_byte(8'hAB, 20, 10);
    @(posedge sys_clk); #1;
    uart_done = 1'b1;
    uart_data = 8'hF2;
    check("f1_fv_before_edge", {31'd0, frame_valid}, 32'd0);
    @(posedge sys_clk); #1;
    check("f1_fv_latency", {31'd0, frame_valid}, 32'd1);
    @(posedge sys_clk); #1;
    check("f1_fv_drop", {31'd0, frame_valid}, 32'd0);
    repeat (18) @(posedge sys_clk);
    #1;
    uart_done = 1'b0;
    uart_data = 8'h00;
    repeat (10) @(posedge sys_clk);
    #1;
    check("f1_fv_count", fv_cnt - fv0, 32'd1);
    check("f1_cmd",   {24'd0, frame_cmd},   32'h01);
    check("f1_addr",  {16'd0, frame_addr},  32'h1234);
    check("f1_wdata", {24'd0, frame_wdata}, 32'hAB);
    check("f1_no_err_chk", ec_cnt - ec0, 32'd0);
    check("f1_no_err_to",  et_cnt - et0, 32'd0);
    check("f1_busy", {31'd0, busy}, 32'd0);

    // Bad checksum F3
    snap();
    send_frame(8'h01, 8'h12, 8'h34, 8'hAB, 8'hF3);
    #1;
    check("f2_err_chk", ec_cnt - ec0, 32'd1);
    check("f2_no_fv",   fv_cnt - fv0, 32'd0);
    check("f2_cmd_held",   {24'd0, frame_cmd},   32'h01);
    check("f2_addr_held",  {16'd0, frame_addr},  32'h1234);
    check("f2_wdata_held", {24'd0, frame_wdata}, 32'hAB);
    check("f2_busy", {31'd0, busy}, 32'd0);

    // Leading garbage, then a frame whose data byte equals the header
    snap();
    send_byte(8'h00, 20, 10);
    send_byte(8'h7E, 20, 10);
    check("f3_idle_after_junk", {31'd0, busy}, 32'd0);
    send_frame(8'h02, 8'h00, 8'h10, 8'h55, 8'h67);
    #1;
    check("f3_fv",    fv_cnt - fv0, 32'd1);
    check("f3_cmd",   {24'd0, frame_cmd},   32'h02);
    check("f3_addr",  {16'd0, frame_addr},  32'h0010);
    check("f3_wdata", {24'd0, frame_wdata}, 32'h55);
    check("f3_no_err", (ec_cnt - ec0) + (et_cnt - et0), 32'd0);

    // Partial frame then silence
    snap();
    send_byte(8'h55, 20, 10);
    send_byte(8'h01, 20, 10);
    send_byte(8'h12, 20, 10);
    repeat (400) @(posedge sys_clk);
    #1;
    check("to_err_timeout", et_cnt - et0, 32'd1);
    check("to_busy", {31'd0, busy}, 32'd0);
    check("to_no_fv", fv_cnt - fv0, 32'd0);
    snap();
    send_frame(8'h03, 8'hAB, 8'hCD, 8'h01, 8'h7C);
    #1;
    check("to_next_fv",   fv_cnt - fv0, 32'd1);
    check("to_next_cmd",  {24'd0, frame_cmd},  32'h03);
    check("to_next_addr", {16'd0, frame_addr}, 32'hABCD);

    // Reset in the middle of a frame
    snap();
    send_byte(8'h55, 20, 10);
    send_byte(8'h01, 20, 10);
    send_byte(8'h12, 20, 10);
    send_byte(8'h34, 20, 10);
    #3;
    sys_rst_n = 1'b0;
    #1;
    check("mr_cmd",   {24'd0, frame_cmd},   32'd0);
    check("mr_addr",  {16'd0, frame_addr},  32'd0);
    check("mr_wdata", {24'd0, frame_wdata}, 32'd0);
    check("mr_busy",  {31'd0, busy},        32'd0);
    #5;
    sys_rst_n = 1'b1;
    send_byte(8'hAB, 20, 10);
    send_byte(8'hF2, 20, 10);
    #1;
    check("mr_tail_no_fv", fv_cnt - fv0, 32'd0);
    check("mr_tail_idle", {31'd0, busy}, 32'd0);
    send_frame(8'h04, 8'h00, 8'hFF, 8'h10, 8'h13);
    #1;
    check("mr_fresh_fv",    fv_cnt - fv0, 32'd1);
    check("mr_fresh_addr",  {16'd0, frame_addr},  32'h00FF);
    check("mr_fresh_wdata", {24'd0, frame_wdata}, 32'h10);

    // Checksum strobe lands exactly on the timeout expiry cycle
    snap();
    send_byte(8'h55, 20, 10);
    send_byte(8'h05, 20, 10);
    send_byte(8'h01, 20, 10);
    send_byte(8'h02, 20, 10);
    send_byte(8'h03, 20, 279);
    send_byte(8'h0B, 20, 10);
    #1;
    check("sim_fv",     fv_cnt - fv0, 32'd1);
    check("sim_no_to",  et_cnt - et0, 32'd0);
    check("sim_cmd",    {24'd0, frame_cmd},   32'h05);
    check("sim_addr",   {16'd0, frame_addr},  32'h0102);
    check("sim_wdata",  {24'd0, frame_wdata}, 32'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
